arbitro_rr_param: RTL and testbench

- Parametrised successor to the fixed 4-channel arbiter of the transaction layer.
- Sits between N_IN input FWFT FIFOs and N_OUT output FIFOs. Each cycle it grants at most one non-empty input, pops one word from it, and pushes that word to the output FIFO selected by the word's dest field.
- Adds three things the fixed arbiter lacks: a runtime-selectable round-robin or fixed-priority mode, a burst quantum (grant is held for up to QUANTUM words), and drop accounting for out-of-range destinations.

---
 rtl/arbitro_rr_param_pkg.sv | 25 ++
 rtl/arbitro_rr_param_if.sv | 31 +++
 rtl/arbitro_rr_param_sel.sv | 40 ++++
 rtl/arbitro_rr_param.sv | 221 ++++++++++++++++++++++
 tb/tb_arbitro_rr_param.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_param_pkg.sv
// Shared definitions for the parametrised round-robin / fixed-priority
// arbiter: mode encoding, FSM state type and a width helper.
package arbitro_pkg;

    // Arbitration mode as driven on the mode input.
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // IDLE: no channel held. HOLD: one channel owns the grant for a burst.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bits needed to index 'value' items (never less than one bit).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/arbitro_rr_param_if.sv
// FIFO-side signal bundle of the arbiter. The arbiter uses the slave view;
// whatever models the FIFOs around it uses the master view.
interface arbitro_rr_param_if #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int DATA_W = 8,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 8
);
    logic                     mode;
    logic [N_IN*DATA_W-1:0]   in_data;
    logic [N_IN*DEST_W-1:0]   in_dest;
    logic [N_IN-1:0]          in_empty;
    logic [N_IN-1:0]          in_pop;
    logic [N_OUT-1:0]         out_full;
    logic [N_OUT-1:0]         out_push;
    logic [DATA_W-1:0]        out_data;
    logic [DEST_W-1:0]        out_dest;
    logic [N_IN-1:0]          grant;
    logic [CNT_W-1:0]         drop_cnt;

    modport master (
        output mode, in_data, in_dest, in_empty, out_full,
        input  in_pop, out_push, out_data, out_dest, grant, drop_cnt
    );

    modport slave (
        input  mode, in_data, in_dest, in_empty, out_full,
        output in_pop, out_push, out_data, out_dest, grant, drop_cnt
    );
endinterface

// File: rtl/arbitro_rr_param_sel.sv
// Rotating priority encoder: picks the first requester at or above the
// start index, wrapping to the lowest requester if none is found there.
// Fixed-priority mode always starts the scan at channel 0.
module arbitro_rr_sel
    import arbitro_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_IN-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             mode,
    output logic [N_IN-1:0]  sel,
    output logic             valid
);

    logic [PTR_W-1:0] start;
    logic [N_IN-1:0]  hi_mask;
    logic [N_IN-1:0]  req_hi;
    logic [N_IN-1:0]  req_pick;

    // Mask off requesters below the start index, then isolate the lowest set bit.
    always_comb begin
        case (mode)
            MODE_RR:    start = ptr;
            MODE_FIXED: start = '0;
            default:    start = '0;
        endcase
        hi_mask = '0;
        for (int i = 0; i < N_IN; i++) begin
            hi_mask[i] = (i >= int'(start));
        end
        req_hi   = req & hi_mask;
        // Nothing at or above start: wrap around to the lowest requester.
        req_pick = (|req_hi) ? req_hi : req;
        sel      = req_pick & (-req_pick);
        valid    = |req;
    end

endmodule

// File: rtl/arbitro_rr_param.sv
// N_IN -> N_OUT FIFO arbiter with burst quantum, runtime round-robin or
// fixed-priority selection, and saturating accounting of words whose
// destination does not exist. Pop is combinational; push is registered.
module arbitro_rr_param
    import arbitro_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 4,
    parameter int DATA_W  = 8,
    parameter int DEST_W  = 4,
    parameter int QUANTUM = 4,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    arbitro_rr_param_if.slave bus
);

    localparam int PTR_W  = clog2(N_IN);
    localparam int HOLD_W = clog2(QUANTUM + 1);

    // Arbitration state
    state_t            state_q, state_d;
    logic [N_IN-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  gidx_q, gidx_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Arbitration helpers
    logic [N_IN-1:0]   elig;
    logic [N_IN-1:0]   arb_sel;
    logic              arb_valid;
    logic [PTR_W-1:0]  arb_ptr;
    logic [PTR_W-1:0]  arb_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic              held_elig;
    logic              keep;
    logic [N_IN-1:0]   pop;
    logic [N_IN-1:0]   pop_eff;

    // Popped word and its routing
    logic [DATA_W-1:0] pop_data;
    logic [DEST_W-1:0] pop_dest;
    logic              pop_any;
    logic [N_OUT-1:0]  push_d;
    logic              drop_d;

    // Output pipeline and drop counter
    logic [N_OUT-1:0]  push_q;
    logic [DATA_W-1:0] data_q;
    logic [DEST_W-1:0] dest_q;
    logic [CNT_W-1:0]  drop_q;

    // A channel may go if it has a word and its destination can take it;
    // words for missing outputs are always takeable since they are dropped.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        elig = '0;
        for (int i = 0; i < N_IN; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                if ((int'(bus.in_dest[i*DEST_W +: DEST_W]) == j) && bus.out_full[j]) begin
                    blocked = 1'b1;
                end
            end
            elig[i] = !bus.in_empty[i] && !blocked;
        end
    end

    assign held_elig = |(elig & grant_q);
    assign keep      = (state_q == HOLD) && held_elig && (hold_q < HOLD_W'(QUANTUM));
    assign next_ptr  = (gidx_q == PTR_W'(N_IN - 1)) ? '0 : gidx_q + PTR_W'(1);
    // On release the scan starts just past the old holder, so it is only
    // re-picked in round-robin mode when nobody else is eligible.
    assign arb_ptr   = (state_q == HOLD) ? next_ptr : rr_ptr_q;

    arbitro_rr_sel #(
        .N_IN  (N_IN),
        .PTR_W (PTR_W)
    ) u_sel (
        .req   (elig),
        .ptr   (arb_ptr),
        .mode  (bus.mode),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    // Convert the one-hot pick into an index for the pointer update.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (arb_sel[i]) begin
                arb_idx = PTR_W'(i);
            end
        end
    end

    // Next-state logic: keep the burst going or re-arbitrate in the same cycle.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        hold_d   = hold_q;
        rr_ptr_d = rr_ptr_q;
        pop      = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    pop     = arb_sel;
                    grant_d = arb_sel;
                    gidx_d  = arb_idx;
                    hold_d  = HOLD_W'(1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (keep) begin
                    pop    = grant_q;
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    // The pointer advances even in fixed-priority mode so a
                    // later switch to round-robin starts from a fair place.
                    rr_ptr_d = next_ptr;
                    if (arb_valid) begin
                        pop     = arb_sel;
                        grant_d = arb_sel;
                        gidx_d  = arb_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        grant_d = '0;
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // No word leaves the upstream FIFOs while reset is held.
    assign pop_eff    = reset ? '0 : pop;
    assign bus.in_pop = pop_eff;
    assign pop_any    = |pop_eff;

    // Select the popped word (at most one channel is popping).
    always_comb begin
        pop_data = '0;
        pop_dest = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (pop_eff[i]) begin
                pop_data = bus.in_data[i*DATA_W +: DATA_W];
                pop_dest = bus.in_dest[i*DEST_W +: DEST_W];
            end
        end
    end

    // Route the popped word to its output, or mark it dropped if out of range.
    always_comb begin
        push_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            push_d[j] = pop_any && (int'(pop_dest) == j);
        end
        drop_d = pop_any && (int'(pop_dest) >= N_OUT);
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of the others, whatever the block order.
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            hold_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output pipeline: the word popped in cycle t is pushed in cycle t+1.
    always_ff @(posedge clk) begin
        // NOTE: the data/dest registers are reset as well, even though push
        // qualifies them, so the outputs read a defined 0 straight out of reset.
        if (reset) begin
            push_q <= '0;
            data_q <= '0;
            dest_q <= '0;
        end else begin
            push_q <= push_d;
            if (|push_d) begin
                data_q <= pop_data;
                dest_q <= pop_dest;
            end
        end
    end

    // Saturating count of words popped for a non-existent output.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop_d && (drop_q != '1)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign bus.out_push = push_q;
    assign bus.out_data = data_q;
    assign bus.out_dest = dest_q;
    assign bus.grant    = grant_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Bench for arbitro_rr_param: behavioural FIFO queues feed the DUT, a
// rule-level model predicts pops, grants, pushes and drops each cycle.
module tb_arbitro_rr_param;
    import arbitro_pkg::*;

    localparam int N_IN    = 4;
    localparam int N_OUT   = 4;
    localparam int DATA_W  = 8;
    localparam int DEST_W  = 4;
    localparam int QUANTUM = 4;
    localparam int CNT_W   = 2;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } word_t;

    logic clk = 1'b0;
    logic reset;

    arbitro_rr_param_if #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)
    ) bus ();

    arbitro_rr_param #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .DEST_W(DEST_W),
        .QUANTUM(QUANTUM), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stimulus queues (the upstream FWFT FIFOs) and observed pushes
    word_t fifo_q[N_IN][$];
    word_t obs_q[$];

    // Driven controls
    logic             mode_r;
    logic [N_OUT-1:0] full_r;
    logic             reset_r;

    // Reference model state
    int               holder;
    int               taken;
    int               rr_ptr;
    logic [N_IN-1:0]  exp_grant;
    logic [N_OUT-1:0] exp_push;
    logic [DATA_W-1:0] exp_data;
    logic [DEST_W-1:0] exp_dest;
    logic [CNT_W-1:0] exp_drop;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N_IN; i++) begin
            if (fifo_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int count_dest(input int d);
        int n;
        n = 0;
        foreach (obs_q[p]) begin
            if (int'(obs_q[p].dest) == d) n++;
        end
        return n;
    endfunction

    task automatic load(input int ch, input int dest, input int data);
        word_t w;
        w.dest = DEST_W'(dest);
        w.data = DATA_W'(data);
        fifo_q[ch].push_back(w);
    endtask

    task automatic drive();
        reset        = reset_r;
        bus.mode     = mode_r;
        bus.out_full = full_r;
        for (int i = 0; i < N_IN; i++) begin
            if (fifo_q[i].size() != 0) begin
                bus.in_empty[i]                  = 1'b0;
                bus.in_data[i*DATA_W +: DATA_W]  = fifo_q[i][0].data;
                bus.in_dest[i*DEST_W +: DEST_W]  = fifo_q[i][0].dest;
            end else begin
                bus.in_empty[i]                  = 1'b1;
                bus.in_data[i*DATA_W +: DATA_W]  = '0;
                bus.in_dest[i*DEST_W +: DEST_W]  = '0;
            end
        end
    endtask

    // Decide which channel the rules say is popped this cycle (-1: none).
    task automatic model_decide(output int pick);
        bit el[N_IN];
        int d;
        int c;
        for (int i = 0; i < N_IN; i++) begin
            if (fifo_q[i].size() == 0) begin
                el[i] = 1'b0;
            end else begin
                d = int'(fifo_q[i][0].dest);
                el[i] = (d >= N_OUT) ? 1'b1 : !full_r[d];
            end
        end
        pick = -1;
        if (holder >= 0 && el[holder] && taken < QUANTUM) begin
            taken++;
            pick = holder;
            return;
        end
        if (holder >= 0) rr_ptr = (holder + 1) % N_IN;
        for (int k = 0; k < N_IN; k++) begin
            c = (mode_r == MODE_FIXED) ? k : (rr_ptr + k) % N_IN;
            if (pick < 0 && el[c]) pick = c;
        end
        holder = pick;
        taken  = (pick >= 0) ? 1 : 0;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic tick();
        int    pick;
        word_t w;
        drive();
        @(negedge clk);
        check("grant", 32'(bus.grant), 32'(exp_grant));
        check("out_push", 32'(bus.out_push), 32'(exp_push));
        if (exp_push != '0) begin
            check("out_data", 32'(bus.out_data), 32'(exp_data));
            check("out_dest", 32'(bus.out_dest), 32'(exp_dest));
        end
        check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
        if (|bus.out_push) begin
            w.dest = bus.out_dest;
            w.data = bus.out_data;
            obs_q.push_back(w);
        end
        if (reset_r) pick = -1;
        else         model_decide(pick);
        check("in_pop", 32'(bus.in_pop), (pick >= 0) ? (32'd1 << pick) : 32'd0);
        if (reset_r) begin
            holder = -1; taken = 0; rr_ptr = 0;
            exp_grant = '0; exp_push = '0; exp_data = '0; exp_dest = '0; exp_drop = '0;
            for (int i = 0; i < N_IN; i++) fifo_q[i].delete();
        end else begin
            exp_push = '0;
            if (pick >= 0) begin
                w = fifo_q[pick].pop_front();
                if (int'(w.dest) < N_OUT) begin
                    exp_push = N_OUT'(1) << w.dest;
                    exp_data = w.data;
                    exp_dest = w.dest;
                end else if (exp_drop != '1) begin
                    exp_drop = exp_drop + CNT_W'(1);
                end
            end
            exp_grant = (holder >= 0) ? (N_IN'(1) << holder) : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !all_empty()) begin
            tick();
            n++;
        end
        check(tag, 32'(all_empty()), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n2;
        int held;
        int k;
        int ch;
        total = 0; bad = 0;
        holder = -1; taken = 0; rr_ptr = 0;
        exp_grant = '0; exp_push = '0; exp_data = '0; exp_dest = '0; exp_drop = '0;
        mode_r = MODE_RR; full_r = '0; reset_r = 1'b1;

        // Reset with everything empty
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_pop",   32'(bus.in_pop),   32'd0);
        check("rst_out_push", 32'(bus.out_push), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_dest", 32'(bus.out_dest), 32'd0);
        check("rst_grant",    32'(bus.grant),    32'd0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset_r = 1'b0;
        repeat (3) tick();
        check("idle_grant", 32'(bus.grant), 32'd0);

        // Quantum round-robin: four channels, eight words each
        obs_q.delete();
        for (int i = 0; i < N_IN; i++) begin
            for (int j = 0; j < 8; j++) load(i, i, i * 16 + j);
        end
        drain("rr_drain", 200);
        check("rr_count", 32'(obs_q.size()), 32'd32);
        for (int p = 0; p < obs_q.size() && p < 32; p++) begin
            ch = (p / 4) % 4;
            k  = (p / 16) * 4 + p % 4;
            check("rr_order", 32'({obs_q[p].dest, obs_q[p].data}), 32'(ch * 256 + ch * 16 + k));
        end

        // Fixed priority: ch1 fully served before ch3
        mode_r = MODE_FIXED;
        obs_q.delete();
        for (int j = 0; j < 6; j++) begin
            load(1, 1, 16 + j);
            load(3, 3, 48 + j);
        end
        drain("fix_drain", 100);
        check("fix_count", 32'(obs_q.size()), 32'd12);
        for (int p = 0; p < obs_q.size() && p < 12; p++) begin
            ch = (p < 6) ? 1 : 3;
            check("fix_order", 32'({obs_q[p].dest, obs_q[p].data}), 32'(ch * 256 + ch * 16 + p % 6));
        end

        // Backpressure on dest 2 after its second push
        mode_r = MODE_RR;
        obs_q.delete();
        for (int j = 0; j < 8; j++) load(0, 2, j);
        for (int j = 0; j < 3; j++) load(1, 1, 16 + j);
        n2 = 0; held = 0;
        for (int c = 0; c < 80 && !all_empty(); c++) begin
            full_r[2] = (n2 >= 2 && held < 5);
            if (full_r[2]) held++;
            tick();
            n2 = count_dest(2);
        end
        full_r = '0;
        drain("bp_drain", 40);
        k = 0;
        foreach (obs_q[p]) begin
            if (int'(obs_q[p].dest) == 2) begin
                check("bp_order", 32'(obs_q[p].data), 32'(k));
                k++;
            end
        end
        check("bp_count", 32'(k), 32'd8);
        check("bp_held", 32'(held), 32'd5);

        // Drops: out-of-range dest, then saturation at 2 bits
        obs_q.delete();
        check("drop_pre", 32'(bus.drop_cnt), 32'd0);
        load(2, 9, 8'hAA);
        repeat (3) tick();
        check("drop_one", 32'(bus.drop_cnt), 32'd1);
        for (int j = 0; j < 4; j++) load(2, 9, j);
        drain("drop_drain", 40);
        check("drop_sat", 32'(bus.drop_cnt), 32'd3);
        check("drop_nopush", 32'(obs_q.size()), 32'd0);

        // Reset in the middle of a burst with a non-zero pointer
        load(2, 0, 0); load(2, 0, 1); load(2, 0, 2); load(2, 0, 3);
        drain("pre_rst_drain", 40);
        for (int j = 0; j < 8; j++) load(1, 1, j);
        for (int c = 0; c < 20 && !(holder == 1 && taken == 2); c++) tick();
        check("hold2_reached", 32'(holder == 1 && taken == 2), 32'd1);
        reset_r = 1'b1;
        tick();
        reset_r = 1'b0;
        check("mid_rst_push",  32'(bus.out_push), 32'd0);
        check("mid_rst_grant", 32'(bus.grant),    32'd0);
        check("mid_rst_drop",  32'(bus.drop_cnt), 32'd0);
        for (int j = 0; j < 4; j++) begin
            load(0, 0, j);
            load(3, 3, 48 + j);
        end
        tick();
        check("rst_first_grant", 32'(bus.grant), 32'd1);
        drain("post_rst_drain", 60);

        // Randomized traffic, backpressure, mode flips and resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_IN; i++) begin
                if ($urandom_range(0, 3) == 0 && fifo_q[i].size() < 6) begin
                    load(i, ($urandom_range(0, 15) == 0) ? 9 : int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
                end
            end
            full_r  = ($urandom_range(0, 3) == 0) ? N_OUT'($urandom) : '0;
            if ($urandom_range(0, 39) == 0) mode_r = ~mode_r;
            reset_r = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset_r = 1'b0;
        full_r  = '0;
        drain("rand_drain", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
